// File: rtl/corescore_framer_pkg.sv
// Shared types and constants for the stream framer: FSM states, line-ending
// characters and the nibble-to-ASCII helper used by the sequence prefix.
package corescore_framer_pkg;

  typedef enum logic [2:0] {IDLE, DATA, CR, LF, SEQ_HI, SEQ_LO, COLON} state_t;

  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_COLON = 8'h3A;

  // '0'..'9' then 'A'..'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/corescore_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra MSB so
// full and empty are distinguishable when the low bits match.
module corescore_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;

endmodule

// File: rtl/corescore_stream_framer.sv
// Buffers tlast-delimited byte frames and re-emits each one followed by CR LF.
// Define CORESCORE_FRAMER_SEQ_EN to prefix every frame with "HH:" (frame count).
module corescore_stream_framer
  import corescore_framer_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        o_tready,
  output logic [7:0]  o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        i_tready,
  output logic [AW:0] o_level,
  output logic [15:0] o_frame_cnt
);

  state_t      state;
  logic        full, empty, push, pop, xfer, cur_last;
  logic [8:0]  fifo_rd;
  logic [15:0] next_cnt;

  assign o_tready = !full;
  assign push     = i_tvalid && !full;
  assign xfer     = o_tvalid && i_tready;
  assign next_cnt = o_frame_cnt + 16'd1;

  corescore_sync_fifo #(.DEPTH(DEPTH), .WIDTH(9)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .wdata ({i_tlast, i_tdata}),
    .pop   (pop),
    .rdata (fifo_rd),
    .full  (full),
    .empty (empty),
    .level (o_level)
  );

  // Pop exactly when the FSM loads a frame byte into the output register.
  always_comb begin
    pop = 1'b0;
    case (state)
`ifdef CORESCORE_FRAMER_SEQ_EN
      COLON: pop = xfer;
`else
      IDLE:  pop = !empty;
      LF:    pop = xfer && !empty;
`endif
      DATA:  pop = xfer && !cur_last && !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_tvalid    <= 1'b0;
      o_tdata     <= '0;
      o_tlast     <= 1'b0;
      cur_last    <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          o_tvalid <= 1'b1;
`ifdef CORESCORE_FRAMER_SEQ_EN
          o_tdata  <= hex_ascii(o_frame_cnt[7:4]);
          state    <= SEQ_HI;
`else
          o_tdata  <= fifo_rd[7:0];
          cur_last <= fifo_rd[8];
          state    <= DATA;
`endif
        end
        DATA: if (xfer) begin
          if (cur_last) begin
            o_tdata <= CHAR_CR;
            state   <= CR;
          end else if (!empty) begin
            o_tdata  <= fifo_rd[7:0];
            cur_last <= fifo_rd[8];
          end else begin
            o_tvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        CR: if (xfer) begin
          o_tdata <= CHAR_LF;
          o_tlast <= 1'b1;
          state   <= LF;
        end
        LF: if (xfer) begin
          o_frame_cnt <= next_cnt;
          o_tlast     <= 1'b0;
          if (!empty) begin
`ifdef CORESCORE_FRAMER_SEQ_EN
            o_tdata  <= hex_ascii(next_cnt[7:4]);
            state    <= SEQ_HI;
`else
            o_tdata  <= fifo_rd[7:0];
            cur_last <= fifo_rd[8];
            state    <= DATA;
`endif
          end else begin
            o_tvalid <= 1'b0;
            state    <= IDLE;
          end
        end
`ifdef CORESCORE_FRAMER_SEQ_EN
        SEQ_HI: if (xfer) begin
          o_tdata <= hex_ascii(o_frame_cnt[3:0]);
          state   <= SEQ_LO;
        end
        SEQ_LO: if (xfer) begin
          o_tdata <= CHAR_COLON;
          state   <= COLON;
        end
        // FIFO was non-empty on entry and nothing has popped since.
        COLON: if (xfer) begin
          o_tdata  <= fifo_rd[7:0];
          cur_last <= fifo_rd[8];
          state    <= DATA;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
